// File: rtl/median9_node_scheduler.sv
// ---------------------------------------------------------------------------
// median9_node_scheduler
//   Time-multiplexed 3x3 median engine. One accepted 9-pixel window is held
//   in a 9-entry register file and pushed through the fixed 19-step
//   median-of-9 compare-exchange network. A single shared Node unit does one
//   step per clock. The median is r[4] once the network has finished.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   window_i holds a valid window
//   in_ready   out  block can accept a window this cycle (combinational)
//   window_i   in   9*DATA_WIDTH, p[k] = window_i[k*DATA_WIDTH +: DATA_WIDTH]
//   out_valid  out  median_o holds a result
//   out_ready  in   downstream accepts the result
//   median_o   out  DATA_WIDTH median, taken straight from r[4]
//   busy_o     out  high while the network is running
//   bypass_i   in   (MEDIAN_BYPASS_EN only) skip the sort and return p[4]
//
// Optional feature macro: MEDIAN_BYPASS_EN
// ---------------------------------------------------------------------------
module median9_node_scheduler #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [9*DATA_WIDTH-1:0] window_i,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   median_o,
    output logic                    busy_o
`ifdef MEDIAN_BYPASS_EN
    ,
    input  logic                    bypass_i
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] LAST_STEP = 5'd18;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [4:0]            r_step;
    logic [DATA_WIDTH-1:0] r_pix [9];

    logic                  w_accept;
    logic                  w_bypass;
    logic [3:0]            w_lo;
    logic [3:0]            w_hi;
    logic [DATA_WIDTH-1:0] w_a;
    logic [DATA_WIDTH-1:0] w_b;
    logic [DATA_WIDTH-1:0] w_min;
    logic [DATA_WIDTH-1:0] w_max;

`ifdef MEDIAN_BYPASS_EN
    assign w_bypass = bypass_i;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_accept = in_valid & in_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (in_valid) w_state_nxt = w_bypass ? DONE : SORT;
            SORT: if (r_step == LAST_STEP) w_state_nxt = DONE;
            DONE: if (out_ready) begin
                // a waiting window loads on the same edge the result leaves
                if (in_valid) w_state_nxt = w_bypass ? DONE : SORT;
                else          w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
        out_valid = (r_state == DONE);
        busy_o    = (r_state == SORT);
    end

    assign median_o = r_pix[4];

    // ---------------- step table: (lo,hi) per network step ----------------
    always_comb begin
        w_lo = 4'd0;
        w_hi = 4'd0;
        case (r_step)
            5'd0:  begin w_lo = 4'd1; w_hi = 4'd2; end
            5'd1:  begin w_lo = 4'd4; w_hi = 4'd5; end
            5'd2:  begin w_lo = 4'd7; w_hi = 4'd8; end
            5'd3:  begin w_lo = 4'd0; w_hi = 4'd1; end
            5'd4:  begin w_lo = 4'd3; w_hi = 4'd4; end
            5'd5:  begin w_lo = 4'd6; w_hi = 4'd7; end
            5'd6:  begin w_lo = 4'd1; w_hi = 4'd2; end
            5'd7:  begin w_lo = 4'd4; w_hi = 4'd5; end
            5'd8:  begin w_lo = 4'd7; w_hi = 4'd8; end
            5'd9:  begin w_lo = 4'd0; w_hi = 4'd3; end
            5'd10: begin w_lo = 4'd5; w_hi = 4'd8; end
            5'd11: begin w_lo = 4'd4; w_hi = 4'd7; end
            5'd12: begin w_lo = 4'd3; w_hi = 4'd6; end
            5'd13: begin w_lo = 4'd1; w_hi = 4'd4; end
            5'd14: begin w_lo = 4'd2; w_hi = 4'd5; end
            5'd15: begin w_lo = 4'd4; w_hi = 4'd7; end
            5'd16: begin w_lo = 4'd4; w_hi = 4'd2; end
            5'd17: begin w_lo = 4'd6; w_hi = 4'd4; end
            5'd18: begin w_lo = 4'd4; w_hi = 4'd2; end
            default: begin w_lo = 4'd0; w_hi = 4'd0; end
        endcase
    end

    // ---------------- shared Node compare-exchange ----------------
    assign w_a   = r_pix[w_lo];
    assign w_b   = r_pix[w_hi];
    assign w_min = (w_a > w_b) ? w_b : w_a;
    assign w_max = (w_a > w_b) ? w_a : w_b;

    // ---------------- register file and step counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step <= '0;
            for (int k = 0; k < 9; k++) r_pix[k] <= '0;
        end else if (w_accept) begin
            r_step <= '0;
            for (int k = 0; k < 9; k++) r_pix[k] <= window_i[k*DATA_WIDTH +: DATA_WIDTH];
        end else if (r_state == SORT) begin
            r_pix[w_lo] <= w_min;
            r_pix[w_hi] <= w_max;
            if (r_step != LAST_STEP) r_step <= r_step + 5'd1;
        end
    end

endmodule
